// File: rtl/scan_chain_loader.sv
// -----------------------------------------------------------------------------
// scan_chain_loader
//
// Loads a CHAIN_LEN-bit configuration scan chain from a byte stream while
// reading back the chain's previous contents. Bytes arrive on a valid/ready
// handshake. They are serialised MSB first onto SCAN_SIN with SCAN_CE
// asserted. Whatever falls out of SCAN_SOUT during the same CE cycles is
// regrouped into bytes on DOUT.
//
// Ports
//   clk_i         clock, rising edge only
//   rst_i         synchronous, active-high reset
//   start_i       begin one load pass (only looked at while idle)
//   din_i         configuration byte, shifted out MSB first
//   din_valid_i   din_i holds a byte
//   din_ready_o   byte accepted when din_valid_i and din_ready_o are both high
//   scan_ce_o     chain shift enable
//   scan_sin_o    serial data into the chain
//   scan_sout_i   serial data out of the chain (readback)
//   dout_o        readback byte, held between pulses
//   dout_valid_o  one-cycle pulse when dout_o updates (no backpressure)
//   busy_o        a pass is in progress
//   done_o        the last pass ran to completion
// -----------------------------------------------------------------------------
module scan_chain_loader #(
  parameter int CHAIN_LEN = 704
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] din_i,
  input  logic       din_valid_i,
  output logic       din_ready_o,
  output logic       scan_ce_o,
  output logic       scan_sin_o,
  input  logic       scan_sout_i,
  output logic [7:0] dout_o,
  output logic       dout_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  // The counter is at least 5 bits wide so the "8 or more bits left"
  // comparison stays meaningful even for very short chains.
  localparam int CNT_RAW = $clog2(CHAIN_LEN + 1);
  localparam int CNT_W   = (CNT_RAW < 5) ? 5 : CNT_RAW;
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;   // bits sent this pass
  logic [2:0]       bitpos_q, bitpos_d;   // bit index within current byte
  logic [3:0]       len_q,    len_d;      // bits to send from current byte
  logic [7:0]       shreg_q,  shreg_d;
  logic [7:0]       cap_q,    cap_d;      // readback capture register
  logic [2:0]       capcnt_q, capcnt_d;   // bits held in cap_q
  logic [7:0]       dout_q,   dout_d;
  logic             dval_q,   dval_d;
  logic             done_q,   done_d;

  logic             ce;
  logic [CNT_W-1:0] cnt_inc;
  logic             chain_end;
  logic             byte_last;
  logic             din_ready;
  logic             accept;
  logic [7:0]       cap_shift;
  logic [3:0]       cap_n;

  // Number of bits to take from the next byte: a full byte, or only what is
  // left of the chain. The low bits of a final partial byte are never sent.
  function automatic logic [3:0] byte_len(input logic [CNT_W-1:0] sent);
    logic [CNT_W-1:0] rem;
    rem = LEN_C - sent;
    if (rem >= CNT_W'(8)) begin
      byte_len = 4'd8;
    end else begin
      byte_len = rem[3:0];
    end
  endfunction

  // Move an n-bit capture (n = 1..8, held in the low bits) to the MSB end
  // and fill the rest with zeros.
  function automatic logic [7:0] left_justify(input logic [7:0] bits,
                                              input logic [3:0] n);
    left_justify = bits << (4'd8 - n);
  endfunction

  assign ce        = (state_q == ST_SHIFT);
  assign cnt_inc   = bitcnt_q + CNT_W'(1);
  assign chain_end = ce && (cnt_inc == LEN_C);
  assign byte_last = ce && ({1'b0, bitpos_q} == (len_q - 4'd1));

  // Ready is offered on the last bit of a byte as well as in WAIT. A byte
  // taken in that cycle is shifted on the very next edge, so CE has no gap.
  assign din_ready = (state_q == ST_WAIT) || (byte_last && !chain_end);
  assign accept    = din_valid_i && din_ready;

  assign cap_shift = {cap_q[6:0], scan_sout_i};
  assign cap_n     = {1'b0, capcnt_q} + 4'd1;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    bitpos_d = bitpos_q;
    len_d    = len_q;
    shreg_d  = shreg_q;
    cap_d    = cap_q;
    capcnt_d = capcnt_q;
    dout_d   = dout_q;
    dval_d   = 1'b0;
    done_d   = done_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bitcnt_d = '0;
          bitpos_d = '0;
          cap_d    = '0;
          capcnt_d = '0;
          done_d   = 1'b0;
          state_d  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (accept) begin
          shreg_d  = din_i;
          len_d    = byte_len(bitcnt_q);
          bitpos_d = '0;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shreg_d  = {shreg_q[6:0], 1'b0};
        bitcnt_d = cnt_inc;
        bitpos_d = bitpos_q + 3'd1;

        // A full readback byte, or the remainder at the end of the chain,
        // is published on this edge so the pulse shows in the next cycle.
        if ((capcnt_q == 3'd7) || chain_end) begin
          dout_d   = left_justify(cap_shift, cap_n);
          dval_d   = 1'b1;
          cap_d    = '0;
          capcnt_d = '0;
        end else begin
          cap_d    = cap_shift;
          capcnt_d = capcnt_q + 3'd1;
        end

        if (chain_end) begin
          state_d = ST_FIN;
        end else if (byte_last) begin
          bitpos_d = '0;
          if (accept) begin
            shreg_d = din_i;
            len_d   = byte_len(cnt_inc);
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      bitpos_q <= '0;
      len_q    <= '0;
      shreg_q  <= '0;
      cap_q    <= '0;
      capcnt_q <= '0;
      dout_q   <= '0;
      dval_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      bitpos_q <= bitpos_d;
      len_q    <= len_d;
      shreg_q  <= shreg_d;
      cap_q    <= cap_d;
      capcnt_q <= capcnt_d;
      dout_q   <= dout_d;
      dval_q   <= dval_d;
      done_q   <= done_d;
    end
  end

  assign din_ready_o  = din_ready;
  assign scan_ce_o    = ce;
  assign scan_sin_o   = ce & shreg_q[7];
  assign dout_o       = dout_q;
  assign dout_valid_o = dval_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;

endmodule

// File: tb/tb_scan_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_scan_chain_loader
//
// Three loaders (16, 12 and 21 bit chains) each drive a shift-register model
// of their chain. One instance at a time is selected by sel. The reference
// model keeps, per chain, the history of every bit ever shifted in. A pass is
// expected to emit the first CHAIN_LEN bits of the supplied bytes, and to read
// back the last CHAIN_LEN bits of that history.
// -----------------------------------------------------------------------------
module tb_scan_chain_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       din_valid;
  logic [1:0] sel;

  logic [2:0] rdy_a, ce_a, sin_a, dv_a, busy_a, done_a;
  logic [7:0] dout_a [3];

  logic [15:0] ch0 = '0;
  logic [11:0] ch1 = '0;
  logic [20:0] ch2 = '0;

  int total = 0;
  int bad   = 0;

  scan_chain_loader #(.CHAIN_LEN(16)) u_l16 (
    .clk_i(clk), .rst_i(rst), .start_i(start & (sel == 2'd0)), .din_i(din),
    .din_valid_i(din_valid & (sel == 2'd0)), .din_ready_o(rdy_a[0]),
    .scan_ce_o(ce_a[0]), .scan_sin_o(sin_a[0]), .scan_sout_i(ch0[15]),
    .dout_o(dout_a[0]), .dout_valid_o(dv_a[0]), .busy_o(busy_a[0]),
    .done_o(done_a[0]));

  scan_chain_loader #(.CHAIN_LEN(12)) u_l12 (
    .clk_i(clk), .rst_i(rst), .start_i(start & (sel == 2'd1)), .din_i(din),
    .din_valid_i(din_valid & (sel == 2'd1)), .din_ready_o(rdy_a[1]),
    .scan_ce_o(ce_a[1]), .scan_sin_o(sin_a[1]), .scan_sout_i(ch1[11]),
    .dout_o(dout_a[1]), .dout_valid_o(dv_a[1]), .busy_o(busy_a[1]),
    .done_o(done_a[1]));

  scan_chain_loader #(.CHAIN_LEN(21)) u_l21 (
    .clk_i(clk), .rst_i(rst), .start_i(start & (sel == 2'd2)), .din_i(din),
    .din_valid_i(din_valid & (sel == 2'd2)), .din_ready_o(rdy_a[2]),
    .scan_ce_o(ce_a[2]), .scan_sin_o(sin_a[2]), .scan_sout_i(ch2[20]),
    .dout_o(dout_a[2]), .dout_valid_o(dv_a[2]), .busy_o(busy_a[2]),
    .done_o(done_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRL-style chain models
  always @(posedge clk) begin
    if (ce_a[0]) ch0 <= {ch0[14:0], sin_a[0]};
    if (ce_a[1]) ch1 <= {ch1[10:0], sin_a[1]};
    if (ce_a[2]) ch2 <= {ch2[19:0], sin_a[2]};
  end

  // Stimulus for one pass
  logic [7:0] tx  [3];
  int         gap [3];

  // Reference model state and expectations
  bit          hist [3][$];
  int          m_len, m_nb, m_gap;
  logic [31:0] m_sin_v;
  logic [23:0] m_rd;

  // Observations of the last pass
  int          o_ce_cnt, o_first_ce, o_last_ce, o_end_cyc, o_n_dv, o_last_dv;
  int          o_sin_bad, o_hold_bad, o_done_rise, o_rise_cyc, o_ce_low;
  logic        o_ended, o_rst_hit;
  logic [31:0] o_sin_v;
  logic [23:0] o_rd;
  logic [13:0] o_post;

  function automatic int len_of(input logic [1:0] s);
    case (s)
      2'd0:    len_of = 16;
      2'd1:    len_of = 12;
      default: len_of = 21;
    endcase
  endfunction

  task automatic model_expect(input logic [1:0] s);
    int base;
    logic [7:0] eb;
    m_len = len_of(s);
    m_nb  = (m_len + 7) / 8;
    m_sin_v = '0;
    for (int i = 0; i < m_len; i++) m_sin_v = {m_sin_v[30:0], tx[i/8][7-(i%8)]};
    base = hist[s].size() - m_len;
    m_rd = '0;
    for (int b = 0; b < m_nb; b++) begin
      eb = '0;
      for (int k = 0; k < 8; k++)
        if (b * 8 + k < m_len) eb[7-k] = hist[s][base + b * 8 + k];
      m_rd = {m_rd[15:0], eb};
    end
    m_gap = 0;
    for (int b = 1; b < m_nb; b++) m_gap += gap[b];
  endtask

  task automatic model_commit(input logic [1:0] s, input int nbits);
    for (int i = 0; i < nbits; i++) hist[s].push_back(tx[i/8][7-(i%8)]);
  endtask

  // Runs one pass on instance s. start_at>0 pulses START during the CE cycle
  // with that count; rst_at>0 asserts RST during the CE cycle with that count.
  task automatic run_pass(input logic [1:0] s, input int start_at, input int rst_at);
    int idx, gap_left, nb;
    logic c;
    logic [7:0] prev_dout;
    logic prev_done;
    sel = s;
    nb = (len_of(s) + 7) / 8;
    o_ce_cnt = 0; o_sin_v = '0; o_first_ce = -1; o_last_ce = -1; o_end_cyc = -1;
    o_ended = 1'b0; o_n_dv = 0; o_rd = '0; o_last_dv = -1; o_sin_bad = 0;
    o_hold_bad = 0; o_done_rise = 0; o_rise_cyc = -1; o_rst_hit = 1'b0; o_post = '1;
    prev_dout = dout_a[s];
    prev_done = done_a[s];
    idx = 0;
    gap_left = gap[0];
    start = 1'b1;
    din_valid = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      c = ce_a[s];
      if (c) begin
        o_ce_cnt++;
        o_sin_v = {o_sin_v[30:0], sin_a[s]};
        if (o_first_ce < 0) o_first_ce = cyc;
        o_last_ce = cyc;
      end else if (sin_a[s] !== 1'b0) begin
        o_sin_bad++;
      end
      if (dv_a[s]) begin
        o_n_dv++;
        o_rd = {o_rd[15:0], dout_a[s]};
        o_last_dv = cyc;
      end else if (dout_a[s] !== prev_dout) begin
        o_hold_bad++;
      end
      prev_dout = dout_a[s];
      if (done_a[s] && !prev_done) begin
        o_done_rise++;
        o_rise_cyc = cyc;
      end
      prev_done = done_a[s];
      if (!busy_a[s]) begin
        o_end_cyc = cyc;
        o_ended = 1'b1;
        break;
      end
      if (c && o_ce_cnt == rst_at) begin
        o_rst_hit = 1'b1;
        rst = 1'b1;
        din_valid = 1'b0;
        break;
      end
      if (c && o_ce_cnt == start_at) start = 1'b1;
      if (idx < nb) begin
        din = tx[idx];
        if (rdy_a[s] && gap_left > 0) begin
          din_valid = 1'b0;
          gap_left--;
        end else begin
          din_valid = 1'b1;
          if (rdy_a[s]) begin
            idx++;
            gap_left = (idx < nb) ? gap[idx] : 0;
          end
        end
      end else begin
        din_valid = 1'b0;
      end
    end
    din_valid = 1'b0;
    start = 1'b0;
    if (o_rst_hit) begin
      @(negedge clk);
      rst = 1'b0;
      o_post = {ce_a[s], sin_a[s], rdy_a[s], dv_a[s], busy_a[s], done_a[s], dout_a[s]};
    end
    o_ce_low = (o_first_ce < 0) ? -1 : (o_last_ce - o_first_ce + 1 - o_ce_cnt);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      total++;
      if ({rdy_a[s], ce_a[s], sin_a[s], dv_a[s], busy_a[s], done_a[s], dout_a[s]} !== 14'h0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d: got rdy=%b ce=%b sin=%b dv=%b busy=%b done=%b dout=%h, want all 0",
                 s, rdy_a[s], ce_a[s], sin_a[s], dv_a[s], busy_a[s], done_a[s], dout_a[s]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic16;
    tx[0] = 8'hA5; tx[1] = 8'h3C; tx[2] = 8'h00;
    gap[0] = 0; gap[1] = 0; gap[2] = 0;
    model_expect(2'd0);
    run_pass(2'd0, 0, 0);
    model_commit(2'd0, 16);
    total++;
    if (o_ended !== 1'b1) begin bad++; $display("FAIL basic_timeout: got ended=%b want 1", o_ended); end
    total++;
    if (o_ce_cnt != 16) begin bad++; $display("FAIL basic_ce_count: got %0d want 16", o_ce_cnt); end
    total++;
    if (o_sin_v !== 32'h0000A53C) begin bad++; $display("FAIL basic_sin: got %h want 0000a53c", o_sin_v); end
    total++;
    if (o_ce_low != 0) begin bad++; $display("FAIL basic_ce_gapless: got %0d low cycles want 0", o_ce_low); end
    total++;
    if (o_end_cyc != o_last_ce + 2) begin bad++; $display("FAIL basic_fin_timing: got idle at %0d want %0d", o_end_cyc, o_last_ce + 2); end
    total++;
    if (o_done_rise != 1 || o_rise_cyc != o_end_cyc || done_a[0] !== 1'b1) begin
      bad++; $display("FAIL basic_done: got rises=%0d at %0d done=%b want 1 at %0d done=1", o_done_rise, o_rise_cyc, done_a[0], o_end_cyc);
    end
    total++;
    if (o_n_dv != 2 || o_rd !== m_rd) begin bad++; $display("FAIL basic_readback: got n=%0d %h want n=2 %h", o_n_dv, o_rd, m_rd); end
  endtask

  task automatic test_readback16;
    tx[0] = 8'h00; tx[1] = 8'h00;
    gap[0] = 1; gap[1] = 0;
    model_expect(2'd0);
    run_pass(2'd0, 0, 0);
    model_commit(2'd0, 16);
    total++;
    if (o_n_dv != 2 || o_rd !== 24'h00A53C) begin bad++; $display("FAIL readback16: got n=%0d %h want n=2 00a53c", o_n_dv, o_rd); end
    total++;
    if (o_hold_bad != 0 || o_sin_bad != 0) begin bad++; $display("FAIL readback16_hold: got hold=%0d sin_idle=%0d want 0 0", o_hold_bad, o_sin_bad); end
  endtask

  task automatic test_partial12;
    for (int p = 0; p < 2; p++) begin
      tx[0] = 8'hFF; tx[1] = 8'hF0;
      gap[0] = 0; gap[1] = 0;
      model_expect(2'd1);
      run_pass(2'd1, 0, 0);
      model_commit(2'd1, 12);
      total++;
      if (o_ce_cnt != 12 || o_sin_v !== 32'h00000FFF) begin
        bad++; $display("FAIL partial12_sin pass=%0d: got n=%0d %h want n=12 00000fff", p, o_ce_cnt, o_sin_v);
      end
      total++;
      if (o_rd !== m_rd || o_n_dv != 2) begin bad++; $display("FAIL partial12_model pass=%0d: got n=%0d %h want n=2 %h", p, o_n_dv, o_rd, m_rd); end
    end
    total++;
    if (o_rd !== 24'h00FFF0) begin bad++; $display("FAIL partial12_readback: got %h want 00fff0", o_rd); end
    total++;
    if (o_last_dv != o_last_ce + 1) begin bad++; $display("FAIL partial12_fin_pulse: got cycle %0d want %0d", o_last_dv, o_last_ce + 1); end
  endtask

  task automatic test_gap;
    tx[0] = 8'($urandom); tx[1] = 8'($urandom);
    gap[0] = 0; gap[1] = 5;
    model_expect(2'd0);
    run_pass(2'd0, 0, 0);
    model_commit(2'd0, 16);
    total++;
    if (o_ce_low != 5) begin bad++; $display("FAIL gap_ce_low: got %0d want 5", o_ce_low); end
    total++;
    if (o_ce_cnt != 16 || o_sin_v !== m_sin_v) begin bad++; $display("FAIL gap_sin: got n=%0d %h want n=16 %h", o_ce_cnt, o_sin_v, m_sin_v); end
    total++;
    if (o_rd !== m_rd) begin bad++; $display("FAIL gap_readback: got %h want %h", o_rd, m_rd); end
  endtask

  task automatic test_reset_mid;
    tx[0] = 8'($urandom); tx[1] = 8'($urandom);
    gap[0] = 0; gap[1] = 0;
    run_pass(2'd0, 0, 3);
    model_commit(2'd0, 3);
    total++;
    if (o_rst_hit !== 1'b1 || o_post !== 14'h0) begin
      bad++; $display("FAIL reset_mid_outputs: got hit=%b post=%h want hit=1 post=0000", o_rst_hit, o_post);
    end
    tx[0] = 8'($urandom); tx[1] = 8'($urandom);
    model_expect(2'd0);
    run_pass(2'd0, 0, 0);
    model_commit(2'd0, 16);
    total++;
    if (o_ended !== 1'b1 || o_ce_cnt != 16 || o_sin_v !== m_sin_v) begin
      bad++; $display("FAIL reset_mid_repass: got ended=%b n=%0d %h want 1 16 %h", o_ended, o_ce_cnt, o_sin_v, m_sin_v);
    end
    total++;
    if (o_rd !== m_rd || o_done_rise != 1) begin bad++; $display("FAIL reset_mid_readback: got %h rises=%0d want %h 1", o_rd, o_done_rise, m_rd); end
  endtask

  task automatic test_start_ignored;
    logic stray;
    tx[0] = 8'($urandom); tx[1] = 8'($urandom);
    gap[0] = 0; gap[1] = 0;
    model_expect(2'd0);
    run_pass(2'd0, 4, 0);
    model_commit(2'd0, 16);
    total++;
    if (o_ce_cnt != 16 || o_done_rise != 1 || o_sin_v !== m_sin_v) begin
      bad++; $display("FAIL start_ignored_pass: got n=%0d rises=%0d %h want 16 1 %h", o_ce_cnt, o_done_rise, o_sin_v, m_sin_v);
    end
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy_a[0] !== 1'b0 || ce_a[0] !== 1'b0 || done_a[0] !== 1'b1) stray = 1'b1;
    end
    total++;
    if (stray !== 1'b0) begin bad++; $display("FAIL start_ignored_idle: got second activity=%b want 0", stray); end
  endtask

  task automatic test_random;
    logic [1:0] s;
    for (int r = 0; r < 24; r++) begin
      s = 2'($urandom_range(0, 2));
      for (int b = 0; b < 3; b++) begin
        tx[b] = 8'($urandom);
        gap[b] = (b == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      end
      model_expect(s);
      run_pass(s, 0, 0);
      model_commit(s, m_len);
      total++;
      if (o_ended !== 1'b1 || o_ce_cnt != m_len) begin
        bad++; $display("FAIL rand%0d_ce_count: got ended=%b n=%0d want 1 %0d", r, o_ended, o_ce_cnt, m_len);
      end
      total++;
      if (o_sin_v !== m_sin_v) begin bad++; $display("FAIL rand%0d_sin: got %h want %h", r, o_sin_v, m_sin_v); end
      total++;
      if (o_ce_low != m_gap) begin bad++; $display("FAIL rand%0d_ce_low: got %0d want %0d", r, o_ce_low, m_gap); end
      total++;
      if (o_n_dv != m_nb || o_rd !== m_rd || o_last_dv != o_last_ce + 1) begin
        bad++; $display("FAIL rand%0d_readback: got n=%0d %h last=%0d want n=%0d %h last=%0d",
                        r, o_n_dv, o_rd, o_last_dv, m_nb, m_rd, o_last_ce + 1);
      end
      total++;
      if (o_end_cyc != o_last_ce + 2 || o_done_rise != 1 || o_rise_cyc != o_end_cyc) begin
        bad++; $display("FAIL rand%0d_fin: got idle=%0d rises=%0d at %0d want idle=%0d rises=1", r, o_end_cyc, o_done_rise, o_rise_cyc, o_last_ce + 2);
      end
      total++;
      if (o_sin_bad != 0 || o_hold_bad != 0) begin bad++; $display("FAIL rand%0d_quiet: got sin_idle=%0d hold=%0d want 0 0", r, o_sin_bad, o_hold_bad); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    din = 8'h00;
    din_valid = 1'b0;
    sel = 2'd0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < len_of(2'(s)); i++) hist[s].push_back(1'b0);
    test_reset;
    test_basic16;
    test_readback16;
    test_partial12;
    test_gap;
    test_reset_mid;
    test_start_ignored;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_chain_loader.md
SCAN_CHAIN_LOADER -- requirements
Module: scan_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 704; number of configuration bits in the target scan chain; legal range 1..65535.
REQ-002 CLK  input  1  clock; all state SHALL change on the rising edge only.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 START  input  1  begins one load pass; sampled only in IDLE.
REQ-005 DIN  input  8  configuration byte, shifted out MSB first.
REQ-006 DIN_VALID  input  1  DIN holds a valid byte.
REQ-007 DIN_READY  output  1  a byte is accepted on any cycle with DIN_VALID and DIN_READY both high.
REQ-008 SCAN_CE  output  1  shift enable to the chain CE.
REQ-009 SCAN_SIN  output  1  serial data to the chain SIN.
REQ-010 SCAN_SOUT  input  1  serial data from the chain SOUT (readback).
REQ-011 DOUT  output  8  readback byte of the previous chain contents.
REQ-012 DOUT_VALID  output  1  one-cycle pulse when DOUT is updated; there is no backpressure.
REQ-013 BUSY  output  1  a load pass is in progress.
REQ-014 DONE  output  1  the last pass completed fully.

Function
REQ-015 The state machine SHALL have exactly four states: IDLE, WAIT, SHIFT and FIN.
REQ-016 IDLE: START=1 SHALL clear the bit counter and DONE and move to WAIT; START in any other state SHALL be ignored.
REQ-017 WAIT: DIN_READY=1; a handshake SHALL load the shift register with DIN and move to SHIFT.
REQ-018 SHIFT: each cycle SHALL drive SCAN_CE=1 and SCAN_SIN=shreg[7], then left-shift shreg and increment the bit counter.
REQ-019 SHIFT length per byte SHALL be min(8, CHAIN_LEN - bits_sent); bits of a final partial byte below that count SHALL be discarded.
REQ-020 On the last bit of a byte, if bits remain: DIN_READY=1 in that same cycle; a handshake SHALL keep SHIFT so the CE stream is gapless; no handshake SHALL move to WAIT.
REQ-021 When the bit counter reaches CHAIN_LEN, the FSM SHALL move to FIN; FIN lasts one cycle, sets DONE=1 and returns to IDLE.
REQ-022 SCAN_CE SHALL be 0 in IDLE, WAIT and FIN; SCAN_SIN SHALL be 0 whenever SCAN_CE=0.
REQ-023 Total asserted SCAN_CE cycles per pass SHALL equal exactly CHAIN_LEN.
REQ-024 Readback: in every cycle with SCAN_CE=1, SCAN_SOUT SHALL be sampled combinationally before the edge and shifted into a capture register, MSB first.
REQ-025 Every 8 captured bits SHALL update DOUT and pulse DOUT_VALID on the following cycle.
REQ-026 A final partial capture SHALL be left-justified and zero-filled, then emitted with DOUT_VALID in the FIN cycle.
REQ-027 DOUT SHALL hold its value between pulses.
REQ-028 BUSY SHALL be 1 in WAIT, SHIFT and FIN, and 0 in IDLE.
REQ-029 DONE SHALL stay 1 from FIN until the next accepted START or RST.
REQ-030 An indefinite DIN_VALID gap in WAIT SHALL stall the pass with SCAN_CE=0; there is no timeout.

Reset
REQ-031 RST SHALL dominate all other inputs.
REQ-032 Next edge after RST=1: state=IDLE, counters=0, shreg=0, capture register=0, and all outputs 0 (DIN_READY, SCAN_CE, SCAN_SIN, DOUT=8'h00, DOUT_VALID, BUSY, DONE).
REQ-033 RST during SHIFT SHALL drop SCAN_CE on that edge; the chain contents are then invalid, DONE=0, and a new START is required.

Verification
REQ-034 CHAIN_LEN=16, START, DIN 8'hA5 then 8'h3C, DIN_VALID held high -> SCAN_CE high for 16 consecutive cycles; SIN=1010_0101_0011_1100; FIN one cycle later; DONE=1, BUSY=0.
REQ-035 Second pass on a 16-bit SRL-model chain after REQ-034, DIN 8'h00 x2 -> DOUT_VALID pulses with 8'hA5 then 8'h3C.
REQ-036 CHAIN_LEN=12, DIN 8'hFF, 8'hF0 -> 12 CE cycles with SIN=1111_1111_1111; second readback byte =8'hF0 (zero-filled), pulsed in FIN.
REQ-037 DIN_VALID deasserted 5 cycles after the first byte -> SCAN_CE low for exactly those 5 cycles (WAIT); total CE count still CHAIN_LEN.
REQ-038 RST at the 3rd SHIFT cycle -> SCAN_CE=0 and BUSY=0 next cycle, DONE=0; a subsequent START performs a full CHAIN_LEN pass.
REQ-039 START pulsed during SHIFT -> ignored; exactly one pass occurs, and DONE rises once.
